sim_end_monitor: RTL and testbench



---
 rtl/sim_end_pkg.sv | 6 +
 rtl/sim_end_drain_cnt.sv | 16 +
 rtl/sim_end_monitor.sv | 109 ++++++++++
 tb/tb_sim_end_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sim_end_pkg.sv
// sim_end_pkg: shared state encoding and cause offsets for the end-of-test monitor.
package sim_end_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, FINISHED} sim_end_state_e;
   localparam int CauseSig     = 0;
   localparam int CauseTimeout = 1;
endpackage

// File: rtl/sim_end_drain_cnt.sv
// sim_end_drain_cnt: loadable 8-bit down-counter that stops at zero.
module sim_end_drain_cnt (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] val_i,
   input  logic       dec_i,
   output logic       zero_o
);
   logic [7:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= 8'd0;
      else         cnt_q <= cnt_d;
   assign zero_o = cnt_q == 8'd0;
endmodule

// File: rtl/sim_end_monitor.sv
// sim_end_monitor: latches the first test-completion event (source, GPIO signature or
// watchdog) with verdict and cause, then requests finish after a drain period.
module sim_end_monitor
   import sim_end_pkg::*;
#(
   parameter int                  NumSrc        = 2,
   parameter int                  SigWidth      = 32,
   parameter logic [SigWidth-1:0] PassSig       = 32'hDEADBEEF,
   parameter logic [SigWidth-1:0] FailSig       = 32'hBAADC0DE,
   parameter int                  DrainCycles   = 7,
   parameter int                  TimeoutCycles = 0,
   parameter int                  CntWidth      = 32,
   localparam int                 IdW           = $clog2(NumSrc + 2)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumSrc-1:0]   src_done_i,
   input  logic [NumSrc-1:0]   src_pass_i,
   input  logic [SigWidth-1:0] sig_i,
   input  logic [SigWidth-1:0] sig_en_i,
   output logic                done_o,
   output logic                pass_o,
   output logic                timeout_o,
   output logic [IdW-1:0]      cause_o,
   output logic                finish_o,
   output logic [CntWidth-1:0] cycles_o
);
   localparam logic [CntWidth-1:0] ToLast = CntWidth'(TimeoutCycles - 1);

   sim_end_state_e      state_q, state_d;
   logic                done_q, done_d, pass_q, pass_d, to_q, to_d;
   logic [IdW-1:0]      cause_q, cause_d, src_idx;
   logic [CntWidth-1:0] cycles_q, cycles_d;
   logic                src_hit, src_pass, sig_pass, sig_fail, to_hit, evt, cnt_zero;
   logic [SigWidth-1:0] sig_eff;

   // Descending scan so the lowest-index asserted source wins.
   always_comb begin
      src_hit  = 1'b0;
      src_pass = 1'b0;
      src_idx  = '0;
      for (int k = NumSrc - 1; k >= 0; k--)
         if (src_done_i[k]) begin
            src_hit  = 1'b1;
            src_pass = src_pass_i[k];
            src_idx  = IdW'(k);
         end
   end

   assign sig_eff  = sig_i & sig_en_i;
   assign sig_pass = sig_eff == PassSig;
   assign sig_fail = sig_eff == FailSig;
   assign to_hit   = (TimeoutCycles != 0) && (cycles_q == ToLast);
   assign evt      = (state_q == RUN) && (src_hit || sig_pass || sig_fail || to_hit);

   always_comb begin
      state_d  = state_q;
      done_d   = done_q;
      pass_d   = pass_q;
      to_d     = to_q;
      cause_d  = cause_q;
      cycles_d = cycles_q;
      if (evt) begin
         state_d = DRAIN;
         done_d  = 1'b1;
         pass_d  = src_hit ? src_pass : sig_pass;
         to_d    = !src_hit && !sig_pass && !sig_fail;
         cause_d = src_hit ? src_idx : (sig_pass || sig_fail) ? IdW'(NumSrc + CauseSig)
                                                              : IdW'(NumSrc + CauseTimeout);
      end else if (state_q == RUN) begin
         cycles_d = &cycles_q ? cycles_q : cycles_q + CntWidth'(1);
      end else if (state_q == DRAIN && cnt_zero) begin
         state_d = FINISHED;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q  <= RUN;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         to_q     <= 1'b0;
         cause_q  <= '0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         to_q     <= to_d;
         cause_q  <= cause_d;
         cycles_q <= cycles_d;
      end

   sim_end_drain_cnt u_drain (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (evt),
      .val_i  (8'(DrainCycles)),
      .dec_i  (state_q == DRAIN),
      .zero_o (cnt_zero)
   );

   assign done_o    = done_q;
   assign pass_o    = pass_q;
   assign timeout_o = to_q;
   assign cause_o   = cause_q;
   assign cycles_o  = cycles_q;
   assign finish_o  = (state_q == DRAIN) && cnt_zero;
endmodule

// File: tb/tb_sim_end_monitor.sv
// tb_sim_end_monitor: two monitor instances (drain 7 / no watchdog, drain 0 / watchdog 50)
// driven by shared stimulus and compared against an event-timeline reference model.
module tb_sim_end_monitor;
   localparam logic [31:0] PS = 32'hDEADBEEF;
   localparam logic [31:0] FS = 32'hBAADC0DE;
   localparam int DR[2] = '{7, 0};
   localparam int TO[2] = '{0, 50};

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  src_done = '0, src_pass = '0;
   logic [31:0] sig = '0, sig_en = '0;
   logic        done_w[2], pass_w[2], to_w[2], fin_w[2];
   logic [1:0]  cause_w[2];
   logic [31:0] cyc_w[2];

   int vec = 0, bad = 0;
   int n_edges = 0;
   int ev_edge[2] = '{-1, -1};
   int ev_cause[2];
   bit ev_pass[2];

   always #5 clk = ~clk;

   sim_end_monitor #(.DrainCycles(7), .TimeoutCycles(0)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .src_done_i(src_done), .src_pass_i(src_pass),
      .sig_i(sig), .sig_en_i(sig_en), .done_o(done_w[0]), .pass_o(pass_w[0]),
      .timeout_o(to_w[0]), .cause_o(cause_w[0]), .finish_o(fin_w[0]), .cycles_o(cyc_w[0]));

   sim_end_monitor #(.DrainCycles(0), .TimeoutCycles(50)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .src_done_i(src_done), .src_pass_i(src_pass),
      .sig_i(sig), .sig_en_i(sig_en), .done_o(done_w[1]), .pass_o(pass_w[1]),
      .timeout_o(to_w[1]), .cause_o(cause_w[1]), .finish_o(fin_w[1]), .cycles_o(cyc_w[1]));

   function automatic bit e_done(int i);  return ev_edge[i] >= 0; endfunction
   function automatic bit e_pass(int i);  return e_done(i) && ev_pass[i]; endfunction
   function automatic bit e_to(int i);    return e_done(i) && ev_cause[i] == 3; endfunction
   function automatic int e_cause(int i); return e_done(i) ? ev_cause[i] : 0; endfunction
   function automatic int e_cyc(int i);   return e_done(i) ? ev_edge[i] : n_edges; endfunction
   function automatic bit e_fin(int i);   return e_done(i) && (n_edges - 1 == ev_edge[i] + DR[i]); endfunction

   // Decide each instance's first event from the inputs about to be sampled, then clock.
   task automatic step();
      for (int i = 0; i < 2; i++)
         if (!e_done(i) && rst_n) begin
            int c = -1;
            bit p = 1'b0;
            for (int k = 0; k < 2; k++)
               if (c < 0 && src_done[k]) begin c = k; p = src_pass[k]; end
            if (c < 0 && (sig & sig_en) == PS) begin c = 2; p = 1'b1; end
            if (c < 0 && (sig & sig_en) == FS) begin c = 2; p = 1'b0; end
            if (c < 0 && TO[i] != 0 && n_edges == TO[i] - 1) begin c = 3; p = 1'b0; end
            if (c >= 0) begin ev_edge[i] = n_edges; ev_cause[i] = c; ev_pass[i] = p; end
         end
      @(posedge clk);
      if (rst_n) n_edges++;
      @(negedge clk);
   endtask

   task automatic clear_in();
      src_done = '0; src_pass = '0; sig = '0; sig_en = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_in();
      repeat (2) @(negedge clk);
      n_edges = 0;
      ev_edge = '{-1, -1};
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         vec++; if (done_w[i] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d] got %b want 0", i, done_w[i]); end
         vec++; if (pass_w[i] !== 1'b0) begin bad++; $display("FAIL reset_pass[%0d] got %b want 0", i, pass_w[i]); end
         vec++; if (to_w[i] !== 1'b0) begin bad++; $display("FAIL reset_timeout[%0d] got %b want 0", i, to_w[i]); end
         vec++; if (cause_w[i] !== 2'd0) begin bad++; $display("FAIL reset_cause[%0d] got %0d want 0", i, cause_w[i]); end
         vec++; if (fin_w[i] !== 1'b0) begin bad++; $display("FAIL reset_finish[%0d] got %b want 0", i, fin_w[i]); end
         vec++; if (cyc_w[i] !== 32'd0) begin bad++; $display("FAIL reset_cycles[%0d] got %0d want 0", i, cyc_w[i]); end
      end
   endtask

   task automatic test_src_priority();
      do_reset();
      repeat (100) step();
      vec++; if (done_w[0] !== 1'b0 || cyc_w[0] !== 32'd100) begin
         bad++; $display("FAIL prio_idle got done=%b cycles=%0d want done=0 cycles=100", done_w[0], cyc_w[0]);
      end
      src_done = 2'b11; src_pass = 2'b10;
      step();
      clear_in();
      vec++; if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b0 || cause_w[0] !== 2'd0 || cyc_w[0] !== 32'd100) begin
         bad++; $display("FAIL prio_latch got done=%b pass=%b cause=%0d cycles=%0d want 1 0 0 100",
                         done_w[0], pass_w[0], cause_w[0], cyc_w[0]);
      end
      for (int c = 101; c <= 112; c++) begin
         vec++; if (fin_w[0] !== (c == 108)) begin
            bad++; $display("FAIL prio_finish cycle %0d got %b want %b", c, fin_w[0], c == 108);
         end
         step();
      end
   endtask

   task automatic test_signature();
      do_reset();
      sig = PS; sig_en = 32'hFFFF0000;
      repeat (3) step();
      vec++; if (done_w[0] !== 1'b0) begin bad++; $display("FAIL sig_masked got done=%b want 0", done_w[0]); end
      sig_en = '1;
      step();
      clear_in();
      vec++; if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b1 || cause_w[0] !== 2'd2 || to_w[0] !== 1'b0) begin
         bad++; $display("FAIL sig_pass got done=%b pass=%b cause=%0d to=%b want 1 1 2 0",
                         done_w[0], pass_w[0], cause_w[0], to_w[0]);
      end
   endtask

   task automatic test_fail_zero_drain();
      do_reset();
      repeat (5) step();
      sig = FS; sig_en = '1;
      step();
      clear_in();
      vec++; if (done_w[1] !== 1'b1 || pass_w[1] !== 1'b0 || cause_w[1] !== 2'd2 || fin_w[1] !== 1'b1) begin
         bad++; $display("FAIL fail_zero got done=%b pass=%b cause=%0d finish=%b want 1 0 2 1",
                         done_w[1], pass_w[1], cause_w[1], fin_w[1]);
      end
      step();
      vec++; if (fin_w[1] !== 1'b0) begin bad++; $display("FAIL fail_zero_once got finish=%b want 0", fin_w[1]); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int c = 1; c <= 60; c++) begin
         step();
         vec++; if (done_w[1] !== (c >= 50) || to_w[1] !== (c >= 50) || fin_w[1] !== (c == 50) ||
                    cyc_w[1] !== 32'(c < 50 ? c : 49)) begin
            bad++; $display("FAIL timeout cycle %0d got done=%b to=%b fin=%b cycles=%0d", c,
                            done_w[1], to_w[1], fin_w[1], cyc_w[1]);
         end
         if (c == 50) begin
            vec++; if (cause_w[1] !== 2'd3 || pass_w[1] !== 1'b0) begin
               bad++; $display("FAIL timeout_cause got cause=%0d pass=%b want 3 0", cause_w[1], pass_w[1]);
            end
         end
      end
   endtask

   task automatic test_drain_reset();
      do_reset();
      src_done = 2'b10; src_pass = 2'b00;
      step();
      for (int c = 0; c < 3; c++) begin
         src_done = 2'b01; src_pass = 2'b01; sig = PS; sig_en = '1;
         step();
         vec++; if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b0 || cause_w[0] !== 2'd1 || to_w[0] !== 1'b0 ||
                    cyc_w[0] !== 32'd0 || fin_w[0] !== 1'b0) begin
            bad++; $display("FAIL drain_hold got done=%b pass=%b cause=%0d to=%b cycles=%0d fin=%b",
                            done_w[0], pass_w[0], cause_w[0], to_w[0], cyc_w[0], fin_w[0]);
         end
      end
      rst_n = 1'b0;
      clear_in();
      #1;
      vec++; if (done_w[0] !== 1'b0 || pass_w[0] !== 1'b0 || cause_w[0] !== 2'd0 || cyc_w[0] !== 32'd0) begin
         bad++; $display("FAIL drain_rst got done=%b pass=%b cause=%0d cycles=%0d want all 0",
                         done_w[0], pass_w[0], cause_w[0], cyc_w[0]);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         vec++; if (fin_w[0] !== 1'b0) begin bad++; $display("FAIL drain_rst_fin got %b want 0", fin_w[0]); end
      end
      n_edges = 0;
      ev_edge = '{-1, -1};
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         vec++; if (fin_w[0] !== 1'b0) begin bad++; $display("FAIL post_rst_fin got %b want 0", fin_w[0]); end
      end
      src_done = 2'b01; src_pass = 2'b01;
      step();
      clear_in();
      vec++; if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b1 || cause_w[0] !== 2'd0 || cyc_w[0] !== 32'd10) begin
         bad++; $display("FAIL post_rst_evt got done=%b pass=%b cause=%0d cycles=%0d want 1 1 0 10",
                         done_w[0], pass_w[0], cause_w[0], cyc_w[0]);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 20; r++) begin
         do_reset();
         for (int c = $urandom_range(10, 60); c > 0; c--) begin
            int s;
            src_done = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            src_pass = 2'($urandom);
            s = $urandom_range(0, 19);
            sig = (s == 0) ? PS : (s == 1) ? FS : $urandom;
            sig_en = $urandom_range(0, 1) ? '1 : $urandom;
            step();
            for (int i = 0; i < 2; i++) begin
               vec++; if (done_w[i] !== e_done(i) || pass_w[i] !== e_pass(i) || to_w[i] !== e_to(i) ||
                          cause_w[i] !== 2'(e_cause(i)) || fin_w[i] !== e_fin(i) || cyc_w[i] !== 32'(e_cyc(i))) begin
                  bad++; $display("FAIL rand[%0d] got d=%b p=%b t=%b c=%0d f=%b n=%0d want d=%b p=%b t=%b c=%0d f=%b n=%0d",
                                  i, done_w[i], pass_w[i], to_w[i], cause_w[i], fin_w[i], cyc_w[i],
                                  e_done(i), e_pass(i), e_to(i), e_cause(i), e_fin(i), e_cyc(i));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_src_priority();
      test_signature();
      test_fail_zero_drain();
      test_timeout();
      test_drain_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
